// File: rtl/ps2_kbd_apb_fifo_pkg.sv
// Shared register map, bit positions and types for the PS/2 keyboard APB controller.
package ps2_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_NONE   = 2'd3;

   localparam int STAT_FERR  = 13;
   localparam int STAT_PERR  = 12;
   localparam int STAT_OVF   = 11;
   localparam int STAT_FULL  = 10;
   localparam int STAT_EMPTY = 9;

   localparam int CTRL_EN = 0;
   localparam int CTRL_IE = 1;

   localparam int FRAME_BITS = 11;

   typedef struct packed {
      logic ferr;
      logic perr;
      logic ovf;
   } ps2_status_t;

   typedef enum logic [1:0] {APB_IDLE, APB_WAIT, APB_READY} apb_state_t;

   function automatic logic [31:0] status_word(input ps2_status_t s, input logic full,
                                               input logic empty, input logic [6:0] count);
      logic [31:0] w;
      w             = '0;
      w[STAT_FERR]  = s.ferr;
      w[STAT_PERR]  = s.perr;
      w[STAT_OVF]   = s.ovf;
      w[STAT_FULL]  = full;
      w[STAT_EMPTY] = empty;
      w[6:0]        = count;
      return w;
   endfunction

endpackage

// File: rtl/ps2_kbd_apb_fifo_rx_frame.sv
// PS/2 device-to-host frame receiver: synchroniser, falling-edge sampler, frame checks
// and an inactivity timeout that abandons partial frames.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int TIMEOUT = 16384
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code,
   output logic       valid,
   output logic       perr,
   output logic       ferr
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          clk_prev;
   logic          fall;
   logic [3:0]    bit_cnt;
   logic [9:0]    shift;
   logic [10:0]   frame;
   logic [TW-1:0] idle_cnt;

   assign fall  = clk_prev & ~clk_sync[1];
   // Bits arrive LSB first: frame[0] start, [8:1] data, [9] parity, [10] stop.
   assign frame = {data_sync[1], shift};

   // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_sync  <= '0;
         data_sync <= '0;
         clk_prev  <= 1'b0;
         bit_cnt   <= '0;
         shift     <= '0;
         idle_cnt  <= '0;
         code      <= '0;
         valid     <= 1'b0;
         perr      <= 1'b0;
         ferr      <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_prev  <= clk_sync[1];
         valid     <= 1'b0;
         perr      <= 1'b0;
         ferr      <= 1'b0;
         if (fall) begin
            idle_cnt <= '0;
            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
               bit_cnt <= '0;
               code    <= frame[8:1];
               if (frame[0] || !frame[10])
                  ferr <= 1'b1;
               else if (!(^frame[9:1]))
                  perr <= 1'b1;
               else
                  valid <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               shift   <= frame[10:1];
            end
         end else if (bit_cnt != '0) begin
            if (idle_cnt == TW'(TIMEOUT - 1)) begin
               bit_cnt  <= '0;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + TW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/ps2_kbd_apb_fifo.sv
// APB-slave PS/2 keyboard controller: scan-code FIFO, sticky error status, control
// register and level interrupt; every APB access takes one wait state.
module ps2_kbd_apb_fifo
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 16384
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] in_paddr,
   input  logic        in_psel,
   input  logic        in_penable,
   input  logic        in_pwrite,
   input  logic [2:0]  in_pprot,
   input  logic [31:0] in_pwdata,
   input  logic [3:0]  in_pstrb,
   output logic        in_pready,
   output logic [31:0] in_prdata,
   output logic        in_pslverr,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic        irq
);

   localparam int            AW         = $clog2(FIFO_DEPTH);
   localparam int            CW         = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   logic [7:0]    rx_code;
   logic          rx_valid, rx_perr, rx_ferr;
   apb_state_t    state;
   logic [1:0]    acc_reg;
   logic          acc_write;
   logic [31:0]   acc_wdata;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   ps2_status_t   sticky, sticky_set, sticky_clr;
   logic          ctrl_en, ctrl_ie;
   logic          full, empty, commit, pop, flush, push_req, do_push, ovf_set, ctrl_wr;
   logic [31:0]   rd_mux;
   logic          unused_bus;

   assign unused_bus = ^{in_pprot, in_pstrb, in_paddr[31:4], in_paddr[1:0]};

   ps2_rx_frame #(.TIMEOUT(TIMEOUT)) u_rx (
      .clock    (clock),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .code     (rx_code),
      .valid    (rx_valid),
      .perr     (rx_perr),
      .ferr     (rx_ferr)
   );

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign commit   = (state == APB_READY);
   assign pop      = commit && !acc_write && (acc_reg == REG_DATA) && !empty;
   assign ctrl_wr  = commit && acc_write && (acc_reg == REG_CTRL);
   assign flush    = ctrl_wr && !acc_wdata[CTRL_EN];
   assign push_req = rx_valid && ctrl_en;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
   assign do_push  = push_req && (!full || pop);
   assign ovf_set  = push_req && full && !pop;

   assign sticky_set = '{ferr: rx_ferr, perr: rx_perr, ovf: ovf_set};
   assign sticky_clr = (commit && acc_write && acc_reg == REG_STATUS)
                       ? '{ferr: acc_wdata[STAT_FERR], perr: acc_wdata[STAT_PERR], ovf: acc_wdata[STAT_OVF]}
                       : '0;

   always_comb begin
      rd_mux = '0;
      if (!in_pwrite) begin
         case (in_paddr[3:2])
            REG_DATA:   if (!empty) rd_mux = {23'b0, 1'b1, mem[rd_ptr]};
            REG_STATUS: rd_mux = status_word(sticky, full, empty, 7'(count));
            REG_CTRL:   rd_mux = {30'b0, ctrl_ie, ctrl_en};
            default:    rd_mux = '0;
         endcase
      end
   end

   // Cycle A captures the access; the READY cycle presents it and commits side effects.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= APB_IDLE;
         in_pready  <= 1'b0;
         in_prdata  <= '0;
         in_pslverr <= 1'b0;
         acc_reg    <= '0;
         acc_write  <= 1'b0;
         acc_wdata  <= '0;
      end else begin
         case (state)
            APB_IDLE, APB_WAIT: begin
               in_pready <= 1'b0;
               if (in_psel && in_penable) begin
                  state      <= APB_READY;
                  in_pready  <= 1'b1;
                  in_prdata  <= rd_mux;
                  in_pslverr <= (in_paddr[3:2] == REG_NONE);
                  acc_reg    <= in_paddr[3:2];
                  acc_write  <= in_pwrite;
                  acc_wdata  <= in_pwdata;
               end else if (in_psel) begin
                  state <= APB_WAIT;
               end else begin
                  state <= APB_IDLE;
               end
            end
            APB_READY: begin
               state      <= APB_IDLE;
               in_pready  <= 1'b0;
               in_prdata  <= '0;
               in_pslverr <= 1'b0;
            end
            default: state <= APB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         sticky  <= '0;
         ctrl_en <= 1'b1;
         ctrl_ie <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !pop)      count <= count + CW'(1);
            else if (pop && !do_push) count <= count - CW'(1);
         end
         if (ctrl_wr) begin
            ctrl_en <= acc_wdata[CTRL_EN];
            ctrl_ie <= acc_wdata[CTRL_IE];
         end
         sticky <= (sticky & ~sticky_clr) | sticky_set;
      end
   end

   // NOTE: the storage array has no reset; the pointers and count alone decide which entries are live.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= rx_code;
   end

   assign irq = ctrl_ie & (!empty | sticky.ovf | sticky.perr | sticky.ferr);

endmodule

// File: tb/tb_ps2_kbd_apb_fifo.sv
// Self-checking bench for ps2_kbd_apb_fifo: register vector table, directed corner
// sequences and randomized frames checked against a queue-based model.
module tb_ps2_kbd_apb_fifo;

   localparam int DEPTH      = 8;
   localparam int TB_TIMEOUT = 512;
   localparam int HALF       = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_paddr = '0;
   logic        in_psel = 1'b0, in_penable = 1'b0, in_pwrite = 1'b0;
   logic [2:0]  in_pprot = '0;
   logic [31:0] in_pwdata = '0;
   logic [3:0]  in_pstrb = 4'hf;
   logic        in_pready;
   logic [31:0] in_prdata;
   logic        in_pslverr;
   logic        ps2_clk = 1'b1, ps2_data = 1'b1;
   logic        irq;

   ps2_kbd_apb_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TB_TIMEOUT)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_paddr   (in_paddr),
      .in_psel    (in_psel),
      .in_penable (in_penable),
      .in_pwrite  (in_pwrite),
      .in_pprot   (in_pprot),
      .in_pwdata  (in_pwdata),
      .in_pstrb   (in_pstrb),
      .in_pready  (in_pready),
      .in_prdata  (in_prdata),
      .in_pslverr (in_pslverr),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .irq        (irq)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] m_q[$];
   logic       m_ovf, m_perr, m_ferr, m_en, m_ie;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
      m_en  = 1'b1; m_ie   = 1'b0;
   endfunction

   function automatic logic [31:0] exp_status();
      logic [31:0] w = '0;
      w[13]  = m_ferr;
      w[12]  = m_perr;
      w[11]  = m_ovf;
      w[10]  = (m_q.size() == DEPTH);
      w[9]   = (m_q.size() == 0);
      w[6:0] = 7'(m_q.size());
      return w;
   endfunction

   function automatic logic exp_irq();
      return m_ie & ((m_q.size() != 0) | m_ovf | m_perr | m_ferr);
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [31:0] data);
      if (addr[3:2] == 2'd1) begin
         if (data[13]) m_ferr = 1'b0;
         if (data[12]) m_perr = 1'b0;
         if (data[11]) m_ovf  = 1'b0;
      end else if (addr[3:2] == 2'd2) begin
         m_en = data[0];
         m_ie = data[1];
         if (!data[0]) m_q.delete();
      end
   endfunction

   // kind: 0 good, 1 bad parity, 2 stop=0, 3 start=1
   function automatic void model_frame(input logic [7:0] code, input int kind);
      if (kind == 2 || kind == 3) m_ferr = 1'b1;
      else if (kind == 1)         m_perr = 1'b1;
      else if (m_en) begin
         if (m_q.size() < DEPTH) m_q.push_back(code);
         else                    m_ovf = 1'b1;
      end
   endfunction

   function automatic logic [10:0] make_frame(input logic [7:0] code, input int kind);
      logic par = ~(^code);
      if (kind == 1) par = ~par;
      return {(kind == 2) ? 1'b0 : 1'b1, par, code, (kind == 3) ? 1'b1 : 1'b0};
   endfunction

   task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
      int waits;
      bit got;
      @(posedge clock); #1;
      in_psel = 1'b1; in_penable = 1'b0; in_paddr = addr; in_pwrite = wr; in_pwdata = wdata;
      in_pprot = 3'($urandom); in_pstrb = 4'($urandom);
      @(posedge clock); #1;
      in_penable = 1'b1;
      got = 1'b0; waits = 99; rdata = '0; err = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clock); #1;
         if (in_pready) begin
            got = 1'b1; waits = i; rdata = in_prdata; err = in_pslverr;
         end
      end
      check("pready_latency", 32'(waits), 32'd0);
      @(posedge clock); #1;
      in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
      check("pready_drop", 32'(in_pready), 32'd0);
   endtask

   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] rd;
      logic err;
      apb(addr, 1'b1, data, rd, err);
      model_write(addr, data);
      check("write_slverr", 32'(err), 32'(addr[3:2] == 2'd3));
   endtask

   task automatic read_status(input string name);
      logic [31:0] rd;
      logic err;
      apb(32'h4, 1'b0, 32'h0, rd, err);
      check(name, rd, exp_status());
   endtask

   task automatic read_data(input string name);
      logic [31:0] rd, exp;
      logic err;
      exp = (m_q.size() != 0) ? {23'b0, 1'b1, m_q[0]} : 32'h0;
      apb(32'h0, 1'b0, 32'h0, rd, err);
      if (m_q.size() != 0) void'(m_q.pop_front());
      check(name, rd, exp);
   endtask

   task automatic check_irq(input string name);
      check(name, 32'(irq), 32'(exp_irq()));
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(posedge clock); #1 ps2_clk = 1'b0;
      repeat (HALF) @(posedge clock); #1 ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] code, input int kind);
      logic [10:0] f = make_frame(code, kind);
      for (int i = 0; i < 11; i++) ps2_bit(f[i]);
      repeat (6) @(posedge clock); #1;
      model_frame(code, kind);
   endtask

   initial begin
      #2_000_000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      vec_t        vecs[17];
      logic [31:0] rd, exp;
      logic        err, seen;
      logic [10:0] f;

      vecs[0]  = '{32'h04, 1'b0, 32'h0,        32'h200, 1'b0};
      vecs[1]  = '{32'h00, 1'b0, 32'h0,        32'h000, 1'b0};
      vecs[2]  = '{32'h08, 1'b0, 32'h0,        32'h001, 1'b0};
      vecs[3]  = '{32'h0C, 1'b0, 32'h0,        32'h000, 1'b1};
      vecs[4]  = '{32'h08, 1'b1, 32'hFFFFFFFF, 32'h000, 1'b0};
      vecs[5]  = '{32'h08, 1'b0, 32'h0,        32'h003, 1'b0};
      vecs[6]  = '{32'h00, 1'b1, 32'h1AB,      32'h000, 1'b0};
      vecs[7]  = '{32'h04, 1'b0, 32'h0,        32'h200, 1'b0};
      vecs[8]  = '{32'h04, 1'b1, 32'h3800,     32'h000, 1'b0};
      vecs[9]  = '{32'h04, 1'b0, 32'h0,        32'h200, 1'b0};
      vecs[10] = '{32'h08, 1'b1, 32'h2,        32'h000, 1'b0};
      vecs[11] = '{32'h08, 1'b0, 32'h0,        32'h002, 1'b0};
      vecs[12] = '{32'h08, 1'b1, 32'h3,        32'h000, 1'b0};
      vecs[13] = '{32'h08, 1'b0, 32'h0,        32'h003, 1'b0};
      vecs[14] = '{32'h1C, 1'b0, 32'h0,        32'h000, 1'b1};
      vecs[15] = '{32'h0C, 1'b1, 32'h5,        32'h000, 1'b1};
      vecs[16] = '{32'h14, 1'b0, 32'h0,        32'h200, 1'b0};

      model_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      check("rst_pready", 32'(in_pready), 32'd0);
      check("rst_prdata", in_prdata, 32'd0);
      check("rst_pslverr", 32'(in_pslverr), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);

      for (int i = 0; i < 17; i++) begin
         apb(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd, err);
         if (vecs[i].wr) model_write(vecs[i].addr, vecs[i].wdata);
         else            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_slverr", i), 32'(err), 32'(vecs[i].exp_err));
      end
      check_irq("irq_ie_empty");

      // Single code 0x1C with IE=1.
      send_frame(8'h1C, 0);
      read_status("status_one");
      check("irq_nonempty", 32'(irq), 32'd1);
      apb(32'h0, 1'b0, 32'h0, rd, err);
      void'(m_q.pop_front());
      check("data_1c", rd, 32'h11C);
      read_data("data_empty");
      check("irq_empty", 32'(irq), 32'd0);

      // Overflow: nine codes into an eight-deep FIFO.
      for (int i = 0; i < 9; i++) send_frame(8'(8'h30 + i * 7), 0);
      read_status("status_full_ovf");
      check_irq("irq_full");
      for (int i = 0; i < 8; i++) read_data($sformatf("drain_ovf%0d", i));
      apb_write(32'h4, 32'h800);
      read_status("status_ovf_cleared");

      // Parity and framing errors.
      send_frame(8'h33, 1);
      send_frame(8'h44, 2);
      read_status("status_perr_ferr");
      check_irq("irq_errors");
      apb_write(32'h4, 32'h3000);
      read_status("status_err_cleared");
      check_irq("irq_cleared");

      // Partial frame abandoned by the inactivity timeout.
      f = make_frame(8'hA5, 0);
      for (int i = 0; i < 5; i++) ps2_bit(f[i]);
      repeat (TB_TIMEOUT + 1) @(posedge clock);
      #1;
      send_frame(8'h5A, 0);
      read_status("status_after_timeout");
      read_data("data_5a");
      read_status("status_timeout_empty");

      // EN=0 flushes and blocks pushes.
      send_frame(8'h21, 0);
      send_frame(8'h22, 0);
      apb_write(32'h8, 32'h2);
      read_status("status_flushed");
      send_frame(8'h23, 0);
      read_status("status_en_off");
      apb_write(32'h8, 32'h3);

      // Full FIFO: the push of 0x77 lands on the same edge as a DATA pop commit.
      for (int i = 0; i < 8; i++) send_frame(8'(8'h90 + i), 0);
      f = make_frame(8'h77, 0);
      for (int i = 0; i < 10; i++) ps2_bit(f[i]);
      ps2_data = f[10];
      repeat (HALF) @(posedge clock);
      #1;
      exp = {23'b0, 1'b1, m_q[0]};
      fork
         begin
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clock);
            #1 ps2_clk = 1'b1;
         end
         apb(32'h0, 1'b0, 32'h0, rd, err);
      join
      void'(m_q.pop_front());
      m_q.push_back(8'h77);
      check("pop_push_data", rd, exp);
      repeat (6) @(posedge clock);
      #1;
      read_status("status_pop_push");
      for (int i = 0; i < 8; i++) read_data($sformatf("drain_pp%0d", i));

      // Randomized frames, reads and W1C against the model.
      for (int n = 0; n < 24; n++) begin
         int kind;
         int r = $urandom_range(0, 9);
         kind = (r < 3) ? r + 1 : 0;
         send_frame(8'($urandom), kind);
         read_status($sformatf("rnd%0d_status", n));
         check_irq($sformatf("rnd%0d_irq", n));
         if ($urandom_range(0, 2) == 0) read_data($sformatf("rnd%0d_data", n));
         if ($urandom_range(0, 4) == 0) apb_write(32'h4, $urandom & 32'h3800);
      end

      // Reset in the middle of a frame and of an APB transfer.
      f = make_frame(8'h12, 0);
      for (int i = 0; i < 5; i++) ps2_bit(f[i]);
      @(posedge clock); #1;
      in_psel = 1'b1; in_penable = 1'b0; in_paddr = 32'h0; in_pwrite = 1'b0;
      @(posedge clock); #1;
      in_penable = 1'b1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0; in_psel = 1'b0; in_penable = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         seen |= in_pready;
         @(posedge clock); #1;
      end
      check("no_pready_after_reset", 32'(seen), 32'd0);
      model_reset();
      read_status("status_after_reset");
      send_frame(8'h66, 0);
      read_status("status_reset_frame");
      read_data("data_66");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
